// File: rtl/prm_edge_mask_engine.sv
// prm_edge_mask_engine: runtime-loadable multi-table SOP cube scanner returning edge_mask and first matching cube index.
// Each query scans one table LANES cubes per cycle with early exit on the lowest hit.
module prm_edge_mask_engine #(
    parameter int IN_W = 15,
    parameter int CUBES = 256,
    parameter int TABLES = 4,
    parameter int LANES = 4,
    localparam int IW = $clog2(CUBES),
    localparam int TW = (TABLES > 1) ? $clog2(TABLES) : 1,
    localparam int LW = $clog2(CUBES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic            cfg_len_we,
    input  logic [TW-1:0]   cfg_table,
    input  logic [IW-1:0]   cfg_addr,
    input  logic [IN_W-1:0] cfg_care,
    input  logic [IN_W-1:0] cfg_value,
    input  logic [LW-1:0]   cfg_len,
    output logic            cfg_err,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [TW-1:0]   in_table,
    input  logic [IN_W-1:0] in_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            edge_mask,
    output logic [IW-1:0]   out_idx
);
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    function automatic logic tbl_ok(input logic [TW-1:0] t);
        return 32'(t) < TABLES;
    endfunction

    state_t          r_state;
    logic [IN_W-1:0] r_care  [TABLES][CUBES];
    logic [IN_W-1:0] r_value [TABLES][CUBES];
    logic [LW-1:0]   r_len   [TABLES];
    logic [TW-1:0]   r_table;
    logic [IN_W-1:0] r_vec;
    logic [IW-1:0]   r_base;
    logic [IW-1:0]   r_idx;
    logic            r_edge;
    logic            r_out_valid;
    logic            r_cfg_err;
    logic            w_cfg_ok;
    logic            w_acc_ok;
    logic [LW-1:0]   w_cfg_len;
    logic [LW-1:0]   w_acc_len;
    logic [LW-1:0]   w_cur_len;
    logic [LW-1:0]   w_next;
    logic [LANES-1:0] w_hit;
    logic [IW-1:0]   w_first;

    assign w_cfg_ok  = (r_state == S_IDLE) && tbl_ok(cfg_table);
    assign w_cfg_len = (cfg_len > LW'(CUBES)) ? LW'(CUBES) : cfg_len;
    // A length written in the accepting cycle must already steer the empty-table shortcut
    assign w_acc_len = (cfg_len_we && w_cfg_ok && cfg_table == in_table) ? w_cfg_len : r_len[in_table];
    assign w_acc_ok  = tbl_ok(in_table) && (w_acc_len != '0);
    assign w_cur_len = r_len[r_table];
    assign w_next    = LW'(r_base) + LW'(LANES);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [IW-1:0] w_a;
        assign w_a      = r_base + IW'(g);
        assign w_hit[g] = (LW'(r_base) + LW'(g) < w_cur_len) &&
                          (((r_vec ^ r_value[r_table][w_a]) & r_care[r_table][w_a]) == '0);
    end

    always_comb begin
        w_first = '0;
        for (int l = LANES - 1; l >= 0; l--)
            if (w_hit[l]) w_first = IW'(l);
    end

    always_ff @(posedge clk) begin
        if (cfg_we && w_cfg_ok) begin
            r_care[cfg_table][cfg_addr]  <= cfg_care;
            r_value[cfg_table][cfg_addr] <= cfg_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_table     <= '0;
            r_vec       <= '0;
            r_base      <= '0;
            r_idx       <= '0;
            r_edge      <= 1'b0;
            r_out_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
            for (int t = 0; t < TABLES; t++) r_len[t] <= '0;
        end else begin
            r_cfg_err <= (cfg_we || cfg_len_we) && !w_cfg_ok;
            if (cfg_len_we && w_cfg_ok) r_len[cfg_table] <= w_cfg_len;
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_table     <= in_table;
                    r_vec       <= in_vec;
                    r_base      <= '0;
                    r_edge      <= 1'b0;
                    r_idx       <= '0;
                    r_state     <= w_acc_ok ? S_SCAN : S_DONE;
                    r_out_valid <= !w_acc_ok;
                end
                S_SCAN: if (|w_hit) begin
                    r_edge      <= 1'b1;
                    r_idx       <= r_base + w_first;
                    r_state     <= S_DONE;
                    r_out_valid <= 1'b1;
                end else if (w_next >= w_cur_len) begin
                    r_state     <= S_DONE;
                    r_out_valid <= 1'b1;
                end else begin
                    r_base <= r_base + IW'(LANES);
                end
                S_DONE: if (out_ready) begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign edge_mask = r_edge;
    assign out_idx   = r_idx;
    assign cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// tb_prm_edge_mask_engine: directed bench for prm_edge_mask_engine.
module tb_prm_edge_mask_engine;
    localparam int IN_W = 15, CUBES = 256, TABLES = 4, LANES = 4, IW = 8, TW = 2, LW = 9;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_we = 1'b0, cfg_len_we = 1'b0;
    logic [TW-1:0]   cfg_table = '0;
    logic [IW-1:0]   cfg_addr = '0;
    logic [IN_W-1:0] cfg_care = '0, cfg_value = '0;
    logic [LW-1:0]   cfg_len = '0;
    logic            cfg_err;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [TW-1:0]   in_table = '0;
    logic [IN_W-1:0] in_vec = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            edge_mask;
    logic [IW-1:0]   out_idx;

    int checks = 0, errors = 0, cyc = 0, acc = 0;

    prm_edge_mask_engine #(.IN_W(IN_W), .CUBES(CUBES), .TABLES(TABLES), .LANES(LANES)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_len_we(cfg_len_we), .cfg_table(cfg_table),
        .cfg_addr(cfg_addr), .cfg_care(cfg_care), .cfg_value(cfg_value), .cfg_len(cfg_len),
        .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready), .in_table(in_table),
        .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready), .edge_mask(edge_mask),
        .out_idx(out_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cube(input int t, input int a, input logic [IN_W-1:0] c, input logic [IN_W-1:0] v);
        cfg_table = TW'(t); cfg_addr = IW'(a); cfg_care = c; cfg_value = v; cfg_we = 1'b1;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic wr_len(input int t, input int l);
        cfg_table = TW'(t); cfg_len = LW'(l); cfg_len_we = 1'b1;
        tick;
        cfg_len_we = 1'b0;
    endtask

    task automatic start(input int t, input logic [IN_W-1:0] v);
        chk("in_ready_pre", in_ready, 1);
        in_table = TW'(t); in_vec = v; in_valid = 1'b1;
        tick;
        acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic finish_q(input string tag, input int elat, input logic eedge, input int eidx, input bit rel);
        while (!out_valid && cyc - acc < 400) tick;
        chk({tag, "_lat"}, out_valid ? 32'(cyc - acc + 1) : 32'hffffffff, 32'(elat));
        chk({tag, "_edge"}, edge_mask, eedge);
        chk({tag, "_idx"}, out_idx, 32'(eidx));
        if (rel) begin
            out_ready = 1'b1;
            tick;
            out_ready = 1'b0;
        end
    endtask

    task automatic run(input string tag, input int t, input logic [IN_W-1:0] v,
                       input int elat, input logic eedge, input int eidx);
        start(t, v);
        finish_q(tag, elat, eedge, eidx, 1'b1);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_edge", edge_mask, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rst = 1'b0;
        tick;

        wr_cube(0, 0, 15'h77DF, 15'h4190);
        wr_len(0, 1);
        run("t0_hit", 0, 15'h4190, 2, 1'b1, 0);
        run("t0_miss", 0, 15'h4191, 2, 1'b0, 0);

        for (int i = 0; i < 8; i++) wr_cube(1, i, 15'h7FFF, 15'h5555);
        wr_cube(1, 5, 15'h7FFF, 15'h0A0A);
        wr_cube(1, 8, 15'h7FFF, 15'h1234);
        wr_cube(1, 9, 15'h0000, 15'h0000);
        wr_len(1, 9);
        run("t1_idx8", 1, 15'h1234, 4, 1'b1, 8);
        run("t1_idx5", 1, 15'h0A0A, 3, 1'b1, 5);
        run("t1_miss", 1, 15'h0000, 4, 1'b0, 0);

        run("t2_empty", 2, 15'h1234, 1, 1'b0, 0);

        start(0, 15'h4190);
        finish_q("stall", 2, 1'b1, 0, 1'b0);
        in_table = 2'd0; in_vec = 15'h4191; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("stall_valid", out_valid, 1);
            chk("stall_edge", edge_mask, 1);
            chk("stall_idx", out_idx, 0);
            chk("stall_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("release_ready", in_ready, 1);
        chk("release_valid", out_valid, 0);
        tick;
        chk("no_reaccept", out_valid, 0);

        start(1, 15'h1234);
        cfg_table = 2'd1; cfg_addr = 8'd8; cfg_care = 15'h7FFF; cfg_value = 15'h0000; cfg_we = 1'b1;
        tick;
        cfg_we = 1'b0;
        chk("scan_cfg_err", cfg_err, 1);
        tick;
        chk("scan_cfg_err_end", cfg_err, 0);
        finish_q("scan_cfg", 4, 1'b1, 8, 1'b1);
        run("rerun", 1, 15'h1234, 4, 1'b1, 8);

        wr_cube(1, 2, 15'h0000, 15'h0000);
        wr_cube(1, 3, 15'h0000, 15'h0000);
        run("t1_idx2", 1, 15'h0000, 2, 1'b1, 2);

        cfg_table = 2'd2; cfg_addr = 8'd0; cfg_care = 15'h0000; cfg_value = 15'h0000; cfg_len = 9'd1;
        cfg_we = 1'b1; cfg_len_we = 1'b1;
        chk("same_cycle_ready", in_ready, 1);
        in_table = 2'd2; in_vec = 15'h3333; in_valid = 1'b1;
        tick;
        acc = cyc;
        cfg_we = 1'b0; cfg_len_we = 1'b0; in_valid = 1'b0;
        chk("same_cycle_err", cfg_err, 0);
        finish_q("same_cycle", 2, 1'b1, 0, 1'b1);

        wr_len(3, 300);
        for (int i = 0; i < CUBES; i++) wr_cube(3, i, 15'h7FFF, 15'h7FFF);
        run("clamp_miss", 3, 15'h0000, 65, 1'b0, 0);
        wr_cube(3, 255, 15'h0000, 15'h0000);
        run("clamp_last", 3, 15'h0000, 65, 1'b1, 255);

        start(3, 15'h0000);
        tick;
        tick;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_ready", in_ready, 1);
        chk("rst_mid_edge", edge_mask, 0);
        #1;
        rst = 1'b0;
        tick;
        run("post_rst_t0", 0, 15'h4190, 1, 1'b0, 0);
        run("post_rst_t1", 1, 15'h0000, 1, 1'b0, 0);
        run("post_rst_t2", 2, 15'h3333, 1, 1'b0, 0);
        run("post_rst_t3", 3, 15'h0000, 1, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prm_edge_mask_engine.md
Name: prm_edge_mask_engine

Overview:
- Programmable, multi-table successor to the fixed single-function obstacle-check blocks.
- Each table holds an obstacle function for one PRM edge set, stored as a sum-of-products cube list (care mask + value per cube).
- A query vector (joint/voxel code) is scanned against one table, LANES cubes per cycle, and returns edge_mask plus the index of the first matching cube.
- Sits between the PRM planner's edge queue (valid/ready) and the collision-result collector; tables are loaded at runtime through a config port.

Parameters:
IN_W, 15, query vector width (bit 0 = A ... bit 14 = O in legacy term notation)
CUBES, 256, max cubes per table
TABLES, 4, number of independent tables
LANES, 4, cubes evaluated per scan cycle (divides CUBES)
IW = $clog2(CUBES), TW = max(1,$clog2(TABLES)), LW = $clog2(CUBES+1) (derived, localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
cfg_we  in  1  write one cube entry
cfg_len_we  in  1  write table cube count
cfg_table  in  TW  target table
cfg_addr  in  IW  cube index
cfg_care  in  IN_W  cube care mask (1 = literal present)
cfg_value  in  IN_W  cube literal polarity
cfg_len  in  LW  cube count for cfg_table
cfg_err  out  1  one-cycle pulse: config write dropped
in_valid  in  1  query valid
in_ready  out  1  engine idle, query accepted
in_table  in  TW  table to scan
in_vec  in  IN_W  query vector
out_valid  out  1  result valid
out_ready  in  1  result consumed
edge_mask  out  1  1 = some cube matched (edge blocked)
out_idx  out  IW  lowest matching cube index; 0 when edge_mask=0

Behaviour:
- Reset: state IDLE, all table lengths 0, in_ready=1, out_valid=0, edge_mask=0, out_idx=0, cfg_err=0. Cube storage is not reset. Reset mid-scan aborts the scan; the result is discarded.
- Cube match: ((in_vec ^ value) & care) == 0. care = 0 matches everything.
- FSM IDLE -> SCAN -> DONE -> IDLE. in_ready = (state==IDLE).
- Acceptance edge (in_valid & in_ready), called cycle 0: latch in_table and in_vec; base = 0.
  - If len(table) = 0: go directly to DONE with edge_mask = 0.
  - Otherwise: go to SCAN.
- SCAN cycle: evaluate cubes base .. base+LANES-1; lanes with index >= len are masked off.
  - Any hit: latch edge_mask=1 and the lowest hitting index, go to DONE (early exit).
  - No hit and base+LANES >= len: edge_mask=0, go to DONE.
  - Otherwise base += LANES.
- Latency: a hit at index i gives out_valid at cycle 2+floor(i/LANES). A miss gives out_valid at cycle 1+ceil(len/LANES). len = 0 gives out_valid at cycle 1.
- DONE: out_valid=1; edge_mask and out_idx held stable until out_ready. On out_valid & out_ready -> IDLE, with in_ready=1 in the next cycle (no same-cycle re-accept).
- Config writes are applied only in IDLE. A write in SCAN or DONE is dropped and cfg_err pulses one cycle later. A config write and an acceptance in the same IDLE cycle: the write lands first, and the scan sees the new data.
- cfg_we and cfg_len_we in the same cycle are both applied.
- cfg_len > CUBES is clamped to CUBES. cfg_table >= TABLES is dropped with cfg_err; in_table >= TABLES returns edge_mask=0 at cycle 1.

Test Plan:
- Load table 0, cube 0: care=0x77DF, value=0x4190, len=1. Query 0x4190 -> out_valid at cycle 2, edge_mask=1, out_idx=0. Query 0x4191 -> edge_mask=0, out_valid at cycle 2.
- Table 1, len=9 (LANES=4), only cube 8 matches 0x1234 (care=0x7FFF, value=0x1234). Query 0x1234 -> out_valid at cycle 4, out_idx=8. Cubes 2 and 3 both care=0: query 0x0000 -> out_idx=2 at cycle 2.
- Table 2 left at len=0 after reset; any query -> edge_mask=0, out_valid at cycle 1.
- Hold out_ready=0 for 5 cycles after a hit -> out_valid, edge_mask and out_idx stable, in_ready=0, and a new in_valid is not accepted. Then pulse out_ready -> in_ready=1 in the next cycle.
- Assert cfg_we during SCAN -> cfg_err pulses, the cube is unchanged, and a rerun query gives the same result. Assert cfg_len_we with 300 -> length reads back as clamped 256 (full scan miss takes 64 SCAN cycles).
- Assert rst mid-SCAN -> out_valid=0, in_ready=1 immediately, and every table returns edge_mask=0 afterwards.
